// File: rtl/ahb_arb_pkg.sv
// Shared encodings for the system AHB arbiter: HTRANS codes, FSM states, master IDs.
package ahb_arb_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Arbiter state
    typedef enum logic [1:0] {
        PARK   = 2'd0,
        OWN    = 2'd1,
        LOCKED = 2'd2
    } arb_state_e;

    // Master IDs on the system bus
    localparam int CPU1 = 0;
    localparam int CPU2 = 1;
    localparam int DMA  = 2;

    // Width of HMASTER / master IDs and of the hold counter
    localparam int MID_W  = 2;
    localparam int HOLD_W = 8;

endpackage

// File: rtl/ahb_bus_arbiter_rr_pick.sv
// Round-robin winner select: scans from owner+1 upward (wrapping), owner last.
module rr_pick
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 3
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MID_W-1:0]       owner,
    output logic [NUM_MASTERS-1:0] win_oh,
    output logic [MID_W-1:0]       win_id,
    output logic                   win_vld
);

    // First requester found after the owner wins; the owner is scanned last
    always_comb begin
        int             idx;
        logic [MID_W-1:0] sel;
        win_oh  = '0;
        win_id  = '0;
        win_vld = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = int'(owner) + k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            sel = MID_W'(idx);
            if (!win_vld && (idx < NUM_MASTERS) && req[sel]) begin
                win_vld     = 1'b1;
                win_id      = sel;
                win_oh[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter for CPU1, CPU2 and DMA with lock, burst and hold-limit handling.
module ahb_bus_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 3,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_HOLD       = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [NUM_MASTERS-1:0] master_en,
    input  logic [1:0]             HTRANS,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MID_W-1:0]       HMASTER,
    output logic [MID_W-1:0]       HMASTER_D,
    output logic                   HMASTLOCK
);

    localparam logic [MID_W-1:0]       DEF_ID   = MID_W'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_OH   = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [HOLD_W-1:0]      HOLD_LIM = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0]      HOLD_MAX = '1;

    arb_state_e             st, st_nxt;
    logic [HOLD_W-1:0]      hold_cnt, hold_nxt;
    logic [NUM_MASTERS-1:0] grant_nxt;
    logic [MID_W-1:0]       owner_nxt;

    logic [NUM_MASTERS-1:0] req;
    logic                   owner_req;
    logic                   others_req;
    logic                   hold_expired;
    logic                   trans_ok;
    logic                   trans_idle;
    logic                   xfer;
    logic                   arb_pt;

    logic [NUM_MASTERS-1:0] win_oh;
    logic [MID_W-1:0]       win_id;
    logic                   win_vld;

    // Requests count only while the master is enabled (CPU2 gated by cpu2_en)
    assign req          = HBUSREQ & master_en;
    // HMASTER doubles as the round-robin pointer: the scan starts after the owner
    assign owner_req    = req[HMASTER];
    assign others_req   = |(req & ~HGRANT);
    assign hold_expired = (hold_cnt >= HOLD_LIM) && others_req;
    // BUSY and SEQ are inside a burst; only IDLE/NONSEQ boundaries allow handover
    assign trans_idle   = (HTRANS == HTRANS_IDLE);
    assign trans_ok     = trans_idle || (HTRANS == HTRANS_NONSEQ);
    assign xfer         = HTRANS[1];

    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_pick (
        .req     (req),
        .owner   (HMASTER),
        .win_oh  (win_oh),
        .win_id  (win_id),
        .win_vld (win_vld)
    );

    // Arbitration point detection and next grant/state selection
    always_comb begin
        st_nxt    = st;
        grant_nxt = HGRANT;
        owner_nxt = HMASTER;
        arb_pt    = 1'b0;
        case (st)
            PARK, OWN: arb_pt = HREADY && trans_ok &&
                                (!owner_req || trans_idle || hold_expired);
            LOCKED:    arb_pt = HREADY && trans_ok && !HLOCK[HMASTER];
            default:   arb_pt = HREADY;
        endcase
        if (arb_pt) begin
            if (win_vld) begin
                grant_nxt = win_oh;
                owner_nxt = win_id;
                st_nxt    = HLOCK[win_id] ? LOCKED : OWN;
            end else begin
                grant_nxt = DEF_OH;
                owner_nxt = DEF_ID;
                st_nxt    = PARK;
            end
        end
    end

    // Hold counter: restarts with each new owner, counts completed address phases
    always_comb begin
        hold_nxt = hold_cnt;
        if (owner_nxt != HMASTER) begin
            hold_nxt = '0;
        end else if (HREADY && xfer && (hold_cnt != HOLD_MAX)) begin
            hold_nxt = hold_cnt + 1'b1;
        end
    end

    // Address-phase owner registers: grant, HMASTER and lock update together
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            st        <= PARK;
            HGRANT    <= DEF_OH;
            HMASTER   <= DEF_ID;
            HMASTLOCK <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            st        <= st_nxt;
            HGRANT    <= grant_nxt;
            HMASTER   <= owner_nxt;
            HMASTLOCK <= (st_nxt == LOCKED);
            hold_cnt  <= hold_nxt;
        end
    end

    // Data-phase owner trails the address phase and freezes through wait states
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            HMASTER_D <= DEF_ID;
        end else if (HREADY) begin
            HMASTER_D <= HMASTER;
        end
    end

endmodule
